pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch register block for the MCU-51 core, directly upstream of the control unit. Drives the CODE address bus from the PC, captures the opcode byte into `IR` and up to two operand bytes into `direct`/`imm`, and holds the relative offset `rel`. The control unit consumes `IR` and `direct`; this block consumes the control unit's `PC_CON` and `IR_en` strobes. Register outputs only, no combinational path from `code_data` to any output.

---
 rtl/mcu51_pkg.sv | 14 +
 rtl/pc_next.sv | 13 +
 rtl/pc_fetch_unit.sv | 88 ++++++++
 tb/tb_pc_fetch_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mcu51_pkg.sv
// mcu51_pkg: shared PC_CON bit indices, operand-counter states and reset defaults
package mcu51_pkg;
  localparam int PC_EN = 3;
  localparam int JUMP = 2;
  localparam int ADD_REL = 1;
  localparam int REL_EN = 0;
  localparam logic [15:0] DEF_RESET_VECTOR = 16'h0000;
  localparam logic [7:0] DEF_NOP_OPCODE = 8'h00;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE = 2'd1,
    FULL = 2'd2
  } opnd_state_e;
endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next-PC select (absolute load, signed relative add, increment)
module pc_next (
  input  logic [15:0] pc_i,
  input  logic [7:0]  rel_i,
  input  logic [7:0]  direct_i,
  input  logic [7:0]  imm_i,
  input  logic        jump_i,
  input  logic        add_rel_i,
  output logic [15:0] pc_o
);
  assign pc_o = jump_i ? {direct_i, imm_i} :
                add_rel_i ? pc_i + {{8{rel_i[7]}}, rel_i} : pc_i + 16'd1;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: MCU-51 program counter, opcode and operand capture registers
module pc_fetch_unit
  import mcu51_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [7:0]  NOP_OPCODE = DEF_NOP_OPCODE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  PC_CON,
  input  logic        IR_en,
  input  logic        opnd_en,
  input  logic [7:0]  code_data,
  output logic [15:0] PC,
  output logic [7:0]  IR,
  output logic [7:0]  direct,
  output logic [7:0]  imm,
  output logic [7:0]  rel,
  output logic [1:0]  opnd_cnt,
  output logic        opnd_ovf
);
  logic [15:0] pc_q, pc_d, pc_nxt;
  logic [7:0] ir_q, ir_d, direct_q, direct_d, imm_q, imm_d, rel_q, rel_d;
  logic ovf_q, ovf_d;
  opnd_state_e state_q, state_d;
  pc_next u_pc_next (
    .pc_i(pc_q),
    .rel_i(rel_q),
    .direct_i(direct_q),
    .imm_i(imm_q),
    .jump_i(PC_CON[JUMP]),
    .add_rel_i(PC_CON[ADD_REL]),
    .pc_o(pc_nxt)
  );
  assign pc_d = PC_CON[PC_EN] ? pc_nxt : pc_q;
  assign rel_d = PC_CON[REL_EN] ? code_data : rel_q;
  // a new opcode restarts operand collection and drops any pending opnd_en
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    direct_d = direct_q;
    imm_d = imm_q;
    ovf_d = ovf_q;
    if (IR_en) begin
      ir_d = code_data;
      state_d = EMPTY;
      direct_d = 8'h00;
      imm_d = 8'h00;
      ovf_d = 1'b0;
    end else if (opnd_en) begin
      if (state_q == EMPTY) begin
        direct_d = code_data;
        state_d = ONE;
      end else if (state_q == ONE) begin
        imm_d = code_data;
        state_d = FULL;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      pc_q <= RESET_VECTOR;
      ir_q <= NOP_OPCODE;
      direct_q <= 8'h00;
      imm_q <= 8'h00;
      rel_q <= 8'h00;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      direct_q <= direct_d;
      imm_q <= imm_d;
      rel_q <= rel_d;
      ovf_q <= ovf_d;
    end
  end
  assign PC = pc_q;
  assign IR = ir_q;
  assign direct = direct_q;
  assign imm = imm_q;
  assign rel = rel_q;
  assign opnd_cnt = state_q;
  assign opnd_ovf = ovf_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and random stimulus against a scoreboarded reference model
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] PC_CON = 4'h0;
  logic IR_en = 1'b0;
  logic opnd_en = 1'b0;
  logic [7:0] code_data = 8'h00;
  logic [15:0] PC;
  logic [7:0] IR, direct, imm, rel;
  logic [1:0] opnd_cnt;
  logic opnd_ovf;

  typedef struct {
    int pc;
    int ir;
    int direct;
    int imm;
    int rel;
    int cnt;
    int ovf;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int checks = 0;
  int errors = 0;

  pc_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .PC_CON(PC_CON),
    .IR_en(IR_en),
    .opnd_en(opnd_en),
    .code_data(code_data),
    .PC(PC),
    .IR(IR),
    .direct(direct),
    .imm(imm),
    .rel(rel),
    .opnd_cnt(opnd_cnt),
    .opnd_ovf(opnd_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("PC", int'(PC), e.pc);
      chk("IR", int'(IR), e.ir);
      chk("direct", int'(direct), e.direct);
      chk("imm", int'(imm), e.imm);
      chk("rel", int'(rel), e.rel);
      chk("opnd_cnt", int'(opnd_cnt), e.cnt);
      chk("opnd_ovf", int'(opnd_ovf), e.ovf);
    end
  end

  task automatic cyc(input bit rst_n, input bit [3:0] pcon, input bit ire, input bit ope,
                     input bit [7:0] data);
    int sext;
    @(negedge clk);
    reset = rst_n;
    PC_CON = pcon;
    IR_en = ire;
    opnd_en = ope;
    code_data = data;
    if (!rst_n) begin
      m = '{pc: 0, ir: 0, direct: 0, imm: 0, rel: 0, cnt: 0, ovf: 0};
    end else begin
      sext = (m.rel >= 128) ? m.rel - 256 : m.rel;
      if (pcon[3])
        m.pc = pcon[2] ? m.direct * 256 + m.imm :
               pcon[1] ? (m.pc + sext + 65536) % 65536 : (m.pc + 1) % 65536;
      if (pcon[0]) m.rel = int'(data);
      if (ire) begin
        m.ir = int'(data);
        m.direct = 0;
        m.imm = 0;
        m.cnt = 0;
        m.ovf = 0;
      end else if (ope) begin
        if (m.cnt == 0) m.direct = int'(data);
        else if (m.cnt == 1) m.imm = int'(data);
        else m.ovf = 1;
        m.cnt = (m.cnt == 2) ? 2 : m.cnt + 1;
      end
    end
    sb.push_back(m);
  endtask

  task automatic load_pc(input bit [15:0] target);
    cyc(1, 4'h0, 1, 0, 8'h02);
    cyc(1, 4'h0, 0, 1, target[15:8]);
    cyc(1, 4'h0, 0, 1, target[7:0]);
    cyc(1, 4'b1100, 0, 0, 8'h00);
  endtask

  initial begin
    m = '{pc: 0, ir: 0, direct: 0, imm: 0, rel: 0, cnt: 0, ovf: 0};
    cyc(0, 4'hF, 1, 1, 8'hFF);
    cyc(0, 4'hF, 1, 1, 8'hFF);
    load_pc(16'hFFFE);
    repeat (3) cyc(1, 4'b1000, 0, 0, 8'h00);
    load_pc(16'h1234);
    load_pc(16'h0102);
    cyc(1, 4'b0001, 0, 1, 8'hFE);
    cyc(1, 4'b1010, 0, 0, 8'h00);
    cyc(1, 4'b1011, 0, 0, 8'h05);
    cyc(1, 4'h0, 1, 0, 8'h12);
    cyc(1, 4'h0, 0, 1, 8'h11);
    cyc(1, 4'h0, 0, 1, 8'h22);
    cyc(1, 4'h0, 0, 1, 8'hAA);
    cyc(1, 4'h0, 1, 0, 8'h74);
    cyc(1, 4'h0, 1, 1, 8'h77);
    cyc(1, 4'b0110, 0, 0, 8'h00);
    cyc(1, 4'h0, 1, 0, 8'h02);
    cyc(1, 4'h0, 0, 1, 8'h12);
    cyc(0, 4'h0, 0, 0, 8'h00);
    cyc(1, 4'b1000, 0, 0, 8'h00);
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 29) != 0), 4'($urandom), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 2) == 0), 8'($urandom));
    @(negedge clk);
    IR_en = 1'b0;
    opnd_en = 1'b0;
    PC_CON = 4'h0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
